// File: rtl/cu_read_command_arbiter_rr.sv
// Round-robin arbiter sharing one read command bus between NUM_REQUESTERS
// per-CU read command controllers. Issues one-cycle one-hot grants, merges
// the popped commands into a single registered stream, and throttles grants
// on downstream almost-full and an in-flight credit counter.
//
// Flattened record layouts:
//   read_command_in_payload : requester i occupies bits [i*DATA_W +: DATA_W]
//   read_buffer_status      : {full, alfull, empty}
module cu_read_command_arbiter_rr #(
    parameter int NUM_REQUESTERS = 4,
    parameter int MAX_INFLIGHT   = 4,
    parameter int DATA_W         = 32,
    localparam int CNT_W         = $clog2(MAX_INFLIGHT + 1),
    localparam int PTR_W         = $clog2(NUM_REQUESTERS)
) (
    input  logic                             clock,
    input  logic                             rst_in,
    input  logic                             enabled_in,
    input  logic [NUM_REQUESTERS-1:0]        read_command_bus_request,
    output logic [NUM_REQUESTERS-1:0]        read_command_bus_grant,
    input  logic [NUM_REQUESTERS-1:0]        read_command_in_valid,
    input  logic [NUM_REQUESTERS*DATA_W-1:0] read_command_in_payload,
    input  logic [2:0]                       read_buffer_status,
    output logic                             read_command_out_valid,
    output logic [DATA_W-1:0]                read_command_out_payload,
    output logic [CNT_W-1:0]                 inflight_count,
    output logic                             collision_error
);

    localparam int STATUS_EMPTY  = 0;
    localparam int STATUS_ALFULL = 1;
    localparam int STATUS_FULL   = 2;
    localparam logic [2:0] STATUS_RESET = 3'b001;

    logic                             enabled;
    logic [NUM_REQUESTERS-1:0]        request_latched;
    logic [NUM_REQUESTERS-1:0]        valid_latched;
    logic [NUM_REQUESTERS*DATA_W-1:0] payload_latched;
    logic [2:0]                       status_latched;
    logic                             status_unused;

    logic [NUM_REQUESTERS-1:0]        grant_reg;
    logic [PTR_W-1:0]                 ptr;

    logic                             arrival;
    logic                             multi_valid;
    logic [DATA_W-1:0]                sel_payload;
    logic                             grant_active;
    logic [CNT_W:0]                   count_plus;
    logic [CNT_W:0]                   count_eff;
    logic                             underflow;
    logic                             credit_ok;
    logic                             do_grant;
    logic [NUM_REQUESTERS-1:0]        rotated;
    logic [PTR_W-1:0]                 offset;
    int                               winner_int;
    logic [PTR_W-1:0]                 winner;
    logic [PTR_W-1:0]                 next_ptr;
    logic [NUM_REQUESTERS-1:0]        grant_next;

    // Only alfull throttles grants; the other status fields are carried for visibility.
    assign status_unused = status_latched[STATUS_EMPTY] ^ status_latched[STATUS_FULL];

    // A grant is visible only while enabled, so disabling can never stretch a pulse.
    assign read_command_bus_grant = grant_reg & {NUM_REQUESTERS{enabled}};
    assign grant_active           = |read_command_bus_grant;

    // Register the global enable.
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) enabled <= 1'b0;
        else        enabled <= enabled_in;
    end

    // Latch control inputs; requests and valids freeze while disabled.
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) begin
            request_latched <= '0;
            valid_latched   <= '0;
            status_latched  <= STATUS_RESET;
        end else begin
            status_latched <= read_buffer_status;
            if (enabled) begin
                request_latched <= read_command_bus_request;
                valid_latched   <= read_command_in_valid;
            end
        end
    end

    // Latch command payloads every cycle; they are qualified by the latched valids.
    always_ff @(posedge clock) begin
        payload_latched <= read_command_in_payload;
    end

    // Arrival detection and lowest-index payload selection.
    always_comb begin
        arrival     = |valid_latched;
        multi_valid = (valid_latched & (valid_latched - NUM_REQUESTERS'(1))) != '0;
        sel_payload = '0;
        for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
            if (valid_latched[i]) sel_payload = payload_latched[i*DATA_W +: DATA_W];
        end
    end

    // Credit projection: count plus the grant now on the bus, minus an arrival.
    always_comb begin
        count_plus = {1'b0, inflight_count} + {{CNT_W{1'b0}}, grant_active};
        underflow  = arrival && (count_plus == '0);
        count_eff  = (arrival && !underflow) ? count_plus - (CNT_W+1)'(1) : count_plus;
        credit_ok  = count_eff < (CNT_W+1)'(MAX_INFLIGHT);
    end

    // Round-robin winner: rotate requests so ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        rotated = NUM_REQUESTERS'({request_latched, request_latched} >> ptr);
        offset  = '0;
        for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
            if (rotated[i]) offset = PTR_W'(i);
        end
        winner_int = int'(ptr) + int'(offset);
        if (winner_int >= NUM_REQUESTERS) winner_int = winner_int - NUM_REQUESTERS;
        winner   = PTR_W'(winner_int);
        next_ptr = (winner_int + 1 == NUM_REQUESTERS) ? '0 : PTR_W'(winner_int + 1);
        do_grant = enabled && !status_latched[STATUS_ALFULL] && credit_ok && (|request_latched);
        grant_next         = '0;
        grant_next[winner] = 1'b1;
    end

    // Grant pulse register and priority pointer.
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) begin
            grant_reg <= '0;
            ptr       <= '0;
        end else if (enabled) begin
            grant_reg <= do_grant ? grant_next : '0;
            if (do_grant) ptr <= next_ptr;
        end else begin
            grant_reg <= '0;
        end
    end

    // In-flight credit counter and sticky collision flag.
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in) begin
            inflight_count  <= '0;
            collision_error <= 1'b0;
        end else if (enabled) begin
            inflight_count <= count_eff[CNT_W-1:0];
            if (multi_valid || underflow) collision_error <= 1'b1;
        end
    end

    // Merged output valid.
    always_ff @(posedge clock or posedge rst_in) begin
        if (rst_in)       read_command_out_valid <= 1'b0;
        else if (enabled) read_command_out_valid <= arrival;
    end

    // Merged output payload; holds between arrivals.
    always_ff @(posedge clock) begin
        if (enabled && arrival) read_command_out_payload <= sel_payload;
    end

endmodule

// File: tb/tb_cu_read_command_arbiter_rr.sv
// Self-checking bench for cu_read_command_arbiter_rr: directed phases followed
// by randomized traffic, compared cycle by cycle against a behavioural model.
module tb_cu_read_command_arbiter_rr;

    localparam int N   = 4;
    localparam int MAX = 4;
    localparam int DW  = 32;

    logic            clock = 1'b0;
    logic            rst_in = 1'b0;
    logic            enabled_in = 1'b0;
    logic [N-1:0]    read_command_bus_request = '0;
    logic [N-1:0]    read_command_bus_grant;
    logic [N-1:0]    read_command_in_valid = '0;
    logic [N*DW-1:0] read_command_in_payload = '0;
    logic [2:0]      read_buffer_status = 3'b001;
    logic            read_command_out_valid;
    logic [DW-1:0]   read_command_out_payload;
    logic [2:0]      inflight_count;
    logic            collision_error;

    cu_read_command_arbiter_rr #(
        .NUM_REQUESTERS(N), .MAX_INFLIGHT(MAX), .DATA_W(DW)
    ) dut (
        .clock                    (clock),
        .rst_in                   (rst_in),
        .enabled_in               (enabled_in),
        .read_command_bus_request (read_command_bus_request),
        .read_command_bus_grant   (read_command_bus_grant),
        .read_command_in_valid    (read_command_in_valid),
        .read_command_in_payload  (read_command_in_payload),
        .read_buffer_status       (read_buffer_status),
        .read_command_out_valid   (read_command_out_valid),
        .read_command_out_payload (read_command_out_payload),
        .inflight_count           (inflight_count),
        .collision_error          (collision_error)
    );

    always #5 clock = ~clock;

    int total = 0;
    int passes = 0;
    int fails = 0;
    int cyc = 0;

    // Behavioural model state
    bit          m_en;
    bit [N-1:0]  m_req_l;
    bit [N-1:0]  m_val_l;
    logic [DW-1:0] m_pay_l [N];
    bit          m_alfull_l;
    int          m_grant;      // index of registered grant, -1 when none
    int          m_ptr;
    int          m_cnt;
    bit          m_out_v;
    logic [DW-1:0] m_out_p;
    bit          m_err;

    // Controller emulation: pending command returns
    int q_due[$];
    int q_idx[$];
    int ret_delay = 0;         // 0: no automatic returns, -1: random 1..4

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_en && m_grant >= 0) g[m_grant] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_en = 0; m_req_l = '0; m_val_l = '0; m_alfull_l = 0;
        m_grant = -1; m_ptr = 0; m_cnt = 0; m_out_v = 0; m_err = 0;
    endtask

    task automatic model_update();
        int n_arr, low, eff, win, j, new_grant;
        n_arr = 0; low = -1; win = -1; new_grant = -1;
        for (int i = 0; i < N; i++) begin
            if (m_val_l[i]) begin
                n_arr++;
                if (low < 0) low = i;
            end
        end
        if (m_en) begin
            eff = m_cnt + ((m_grant >= 0) ? 1 : 0) - ((n_arr > 0) ? 1 : 0);
            if (n_arr > 1 || eff < 0) m_err = 1;
            if (eff < 0) eff = 0;
            if (!m_alfull_l && eff < MAX) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (win < 0 && m_req_l[j]) win = j;
                end
            end
            if (win >= 0) m_ptr = (win + 1) % N;
            new_grant = win;
            m_cnt = eff;
            m_out_v = (n_arr > 0);
            if (n_arr > 0) m_out_p = m_pay_l[low];
            m_req_l = read_command_bus_request;
            m_val_l = read_command_in_valid;
        end
        m_grant = new_grant;
        m_alfull_l = read_buffer_status[1];
        m_en = enabled_in;
    endtask

    task automatic compare();
        chk("grant", read_command_bus_grant, exp_grant());
        chk("inflight_count", inflight_count, m_cnt);
        chk("out_valid", read_command_out_valid, m_out_v);
        chk("collision_error", collision_error, m_err);
        if (m_out_v) chk("out_payload", read_command_out_payload, m_out_p);
    endtask

    // One clock: edge, model, compare, then prepare next-cycle returns and payloads.
    task automatic step();
        logic [N-1:0] v;
        int d;
        @(posedge clock);
        #1;
        cyc++;
        if (rst_in) model_reset();
        else        model_update();
        for (int i = 0; i < N; i++) m_pay_l[i] = read_command_in_payload[i*DW +: DW];
        compare();
        if (m_en && m_grant >= 0 && ret_delay != 0) begin
            d = (ret_delay < 0) ? int'($urandom_range(1, 4)) : ret_delay;
            q_due.push_back(cyc + d);
            q_idx.push_back(m_grant);
        end
        v = '0;
        for (int k = q_due.size() - 1; k >= 0; k--) begin
            if (q_due[k] <= cyc) begin
                v[q_idx[k]] = 1'b1;
                q_due.delete(k);
                q_idx.delete(k);
            end
        end
        read_command_in_valid = v;
        for (int i = 0; i < N; i++) read_command_in_payload[i*DW +: DW] = $urandom;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [DW-1:0] pay0;

    initial begin
        // Reset values
        model_reset();
        #2 rst_in = 1'b1;
        #1;
        chk("reset_grant", read_command_bus_grant, 0);
        chk("reset_out_valid", read_command_out_valid, 0);
        chk("reset_count", inflight_count, 0);
        chk("reset_collision", collision_error, 0);
        run(2);
        rst_in = 1'b0;
        enabled_in = 1'b1;

        // Single requester, commands return 3 cycles after each grant
        read_command_bus_request = 4'b0010;
        ret_delay = 3;
        run(30);

        // All four requesting continuously
        read_command_bus_request = 4'b1111;
        ret_delay = 2;
        run(24);
        read_command_bus_request = 4'b0000;
        run(10);

        // Back-pressure from downstream almost-full
        read_command_bus_request = 4'b1111;
        ret_delay = 3;
        run(5);
        read_buffer_status = 3'b010;
        step();
        for (int i = 0; i < 9; i++) begin
            step();
            chk("alfull_no_grant", read_command_bus_grant, 0);
        end
        read_buffer_status = 3'b001;
        run(12);
        read_command_bus_request = 4'b0000;
        run(10);

        // Credit exhaustion: no commands come back
        ret_delay = 0;
        read_command_bus_request = 4'b1111;
        run(10);
        chk("exhaust_count", inflight_count, 4);
        chk("exhaust_no_grant", read_command_bus_grant, 0);
        read_command_in_valid = 4'b0001;
        step();
        step();
        chk("free_count", inflight_count, 3);
        chk("free_one_grant", |read_command_bus_grant, 1);
        step();
        chk("refill_count", inflight_count, 4);
        chk("refill_no_grant", read_command_bus_grant, 0);

        // Collision of two simultaneous returns
        read_command_bus_request = 4'b0000;
        run(3);
        read_command_in_valid = 4'b0101;
        pay0 = read_command_in_payload[DW-1:0];
        step();
        step();
        chk("collision_out_valid", read_command_out_valid, 1);
        chk("collision_fwd_low", read_command_out_payload, pay0);
        chk("collision_count", inflight_count, 3);
        chk("collision_flag", collision_error, 1);
        run(5);
        chk("collision_sticky", collision_error, 1);

        // Reset in the middle of a burst
        read_command_bus_request = 4'b1111;
        q_due.push_back(cyc + 2); q_idx.push_back(1);
        run(3);
        #2 rst_in = 1'b1;
        #1;
        model_reset();
        chk("midrst_grant", read_command_bus_grant, 0);
        chk("midrst_out_valid", read_command_out_valid, 0);
        chk("midrst_count", inflight_count, 0);
        chk("midrst_collision", collision_error, 0);
        q_due.delete(); q_idx.delete();
        run(2);
        rst_in = 1'b0;
        ret_delay = 2;
        run(12);

        // Randomized traffic
        ret_delay = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            read_command_bus_request = 4'($urandom);
            enabled_in = ($urandom_range(0, 9) != 0);
            read_buffer_status = 3'($urandom);
            read_buffer_status[1] = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0) read_command_in_valid[$urandom_range(0, N-1)] = 1'b1;
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/cu_read_command_arbiter_rr.md
# cu_read_command_arbiter_rr

Round-robin arbiter sharing one read command bus between `NUM_REQUESTERS` per-CU read command controllers, such as edge-data, edge-job and vertex-job fetchers. It answers each controller's `read_command_bus_request` with a one-cycle `read_command_bus_grant`. It merges the commands the granted controllers pop into one registered `CommandBufferLine` stream toward the CU command buffer. Grants are throttled by downstream `BufferStatus.alfull` and by an in-flight credit counter, so granted-but-not-yet-arrived commands can never overflow the downstream buffer.

## Interface
- `NUM_REQUESTERS`, default 4: number of requesting controllers, valid range 2..16.
- `MAX_INFLIGHT`, default 4: maximum grants issued whose command has not yet arrived.
- `clock` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_in` input, 1 bit: reset, asynchronous, active-high.
- `enabled_in` input, 1 bit: global enable; registered internally as `enabled`.
- `read_command_bus_request` input, [NUM_REQUESTERS], one request bit per controller.
- `read_command_bus_grant` output, [NUM_REQUESTERS], one-hot grant pulse.
- `read_command_in` input, CommandBufferLine [NUM_REQUESTERS]: commands popped by the controllers after a grant.
- `read_buffer_status` input, BufferStatus: status of the downstream command buffer.
- `read_command_out` output, CommandBufferLine: merged command stream.
- `inflight_count` output, $clog2(MAX_INFLIGHT+1) bits: current credit usage.
- `collision_error` output, 1 bit: sticky flag, set when more than one `read_command_in[i].valid` is asserted in the same cycle.

## Operation
- **Reset values:** `read_command_bus_grant`=0, `read_command_out.valid`=0, `inflight_count`=0, `collision_error`=0, priority pointer `ptr`=0.
  - Internal copy of `read_buffer_status` resets to 0 with `.empty`=1.
  - Payload registers are not reset.
- **Input registering:** requests, `read_buffer_status` and every `read_command_in[i].valid` are registered on the stage called `*_latched`.
  - Valids and requests are registered only while `enabled`=1 and hold otherwise.
  - Payloads are registered unconditionally.
- **Grant condition:** a grant is issued in a cycle when all of the following hold:
  - `enabled`=1;
  - `read_buffer_status_latched.alfull`=0;
  - `inflight_count` + (grant already in flight this cycle ? 1 : 0) − (arrival this cycle ? 1 : 0) < `MAX_INFLIGHT`;
  - at least one latched request is set.
- **Winner selection:** the winner is the first set latched request scanning from `ptr` upward, modulo `NUM_REQUESTERS`.
  - After a grant to index w, `ptr` ← (w+1) mod N.
  - With no grant, `ptr` holds.
- **Grant shape:** the grant is registered and one-hot, asserted for exactly one cycle per issued grant. Back-to-back grants, including to the same sole requester, are legal.
- **Credit counter:**
  - +1 on each grant issued.
  - −1 on each latched `read_command_in` valid (an arrival).
  - Simultaneous grant and arrival leaves the count unchanged.
  - Never exceeds `MAX_INFLIGHT`.
  - An arrival at count 0 saturates at 0 and sets `collision_error`.
- **Merge:** on an arrival, `read_command_out` ← the latched command of the lowest index with valid set; `.valid`=1 for one cycle.
  - Two or more simultaneous valids: forward the lowest index, decrement the counter by one only, and set `collision_error`.
  - `collision_error` is cleared only by `rst_in`.
- **Disable:** `enabled_in`=0 freezes the grant logic and the counter, and outputs hold their last values.
  - The grant output is forced to 0 while disabled, so no pulse can stretch.
- **Reset mid-operation:** all in-flight credit is discarded. Controllers are required to be reset by the same `rst_in`.

## Timing
- Request at the port in cycle t → latched at t+1 → grant at the port in cycle t+2 (minimum, uncontended).
- `read_command_in[i].valid` in cycle t → latched at t+1 → `read_command_out.valid` at t+2.
- Arbitration throughput is one grant per cycle.
- `alfull` at the port in cycle t blocks grants from cycle t+2 onward. Grants already issued still complete, which is covered by `MAX_INFLIGHT` ≤ the downstream alfull margin.
- `collision_error` asserts 2 cycles after the offending input cycle.

## Test plan
- **Single requester, uncontended:** `read_command_bus_request`=4'b0010 held, `read_command_in[1]` returns valid 3 cycles after each grant.
  - Expect the grant 4'b0010 first at cycle 2, then continuous pulses limited to `MAX_INFLIGHT`=4 in flight.
  - Every command appears on `read_command_out` 2 cycles after its `read_command_in`.
- **All four requesting continuously:**
  - Expect the grant sequence 0001, 0010, 0100, 1000, 0001, and so on.
  - `ptr` wraps from 3 to 0.
- **Credit exhaustion:** no command returns after 4 grants.
  - Expect `inflight_count`=4 and no further grants.
  - One arrival frees exactly one grant 1 cycle later.
  - `inflight_count` stays 4 when a grant and an arrival coincide.
- **Back-pressure:** `read_buffer_status.alfull`=1 from cycle 10.
  - Expect no grant from cycle 12 onward.
  - Deasserting alfull at cycle 20 resumes grants at cycle 22, starting at the held `ptr`.
- **Collision:** valid on `read_command_in[0]` and `read_command_in[2]` in the same cycle.
  - Expect the index-0 command forwarded, the counter decremented by 1, and `collision_error`=1 held until reset.
- **Reset mid-burst:** assert `rst_in` with `inflight_count`=3 and a grant pending.
  - Expect grant=0, `read_command_out.valid`=0, `inflight_count`=0 and `ptr`=0 immediately; normal operation after release.
